// File: rtl/branch_jump_resolve_ctrl.sv
// Control-hazard controller: holds fetch and bubbles ID while a branch/jump is
// unresolved, then issues a one-cycle PC redirect plus IF flush on a taken transfer.
module branch_jump_resolve_ctrl #(
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             id_valid,
  input  logic             id_is_branch_jump,
  input  logic             ex_resolve_valid,
  input  logic             ex_taken,
  input  logic [31:0]      ex_target,
  output logic             if_stall,
  output logic             id_bubble,
  output logic             if_flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_target,
  output logic             misalign_err,
  output logic             timeout_err,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT     = 2'd1;
  localparam logic [1:0] S_REDIRECT = 2'd2;

  localparam int              WW        = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0]   WAIT_LAST = WW'(MAX_WAIT - 1);
  localparam logic [WW-1:0]   ONE_W     = WW'(1);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [WW-1:0] wait_cnt;

  logic detect;
  logic resolve_taken;
  logic resolve_not_taken;
  logic wait_expired;

  assign detect            = id_valid & id_is_branch_jump;
  assign resolve_taken     = ex_resolve_valid & ex_taken;
  assign resolve_not_taken = ex_resolve_valid & ~ex_taken;
  // wait_cnt counts WAIT cycles already spent; this is the MAX_WAIT-th one.
  assign wait_expired      = (wait_cnt == WAIT_LAST);

  // Handshake: a detection is consumed the cycle it is seen in IDLE; EX
  // resolution is only accepted while in WAIT and is a single-cycle strobe.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (detect) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (resolve_taken)          state_nxt = S_REDIRECT;
        else if (resolve_not_taken) state_nxt = S_IDLE;
        else if (wait_expired)      state_nxt = S_IDLE;
      end
      S_REDIRECT: state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state           <= S_IDLE;
      wait_cnt        <= '0;
      redirect_target <= '0;
      misalign_err    <= 1'b0;
      timeout_err     <= 1'b0;
      branch_cnt      <= '0;
      taken_cnt       <= '0;
    end else begin
      state        <= state_nxt;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (detect) begin
            branch_cnt <= branch_cnt + ONE_C;
            wait_cnt   <= '0;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + ONE_W;
          if (resolve_taken) begin
            redirect_target <= {ex_target[31:1], 1'b0};
            taken_cnt       <= taken_cnt + ONE_C;
            misalign_err    <= ex_target[1];
          end else if (!ex_resolve_valid && wait_expired) begin
            timeout_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Stall in IDLE is combinational so the fall-through fetch is held immediately.
  assign if_stall       = (state == S_WAIT) | ((state == S_IDLE) & detect);
  assign id_bubble      = (state == S_WAIT) | (state == S_REDIRECT);
  assign redirect_valid = (state == S_REDIRECT);
  assign if_flush       = (state == S_REDIRECT);

endmodule

// File: doc/branch_jump_resolve_ctrl.md
Name: branch_jump_resolve_ctrl

Overview:
Control-hazard controller that consumes the ID-stage branch/jump flag and handles the pipeline until EX resolves the control transfer.
- On detection it holds fetch and bubbles ID.
- It waits for EX to report taken/not-taken and the target.
- On a taken transfer it issues a one-cycle PC redirect and flushes IF.
- Sits between the ID-stage branch/jump detector, the EX branch unit and the PC/IF-ID pipeline register.

Parameters:
MAX_WAIT, 8, maximum cycles spent in WAIT before timeout abort (≥1).
CNT_W, 32, width of the branch and taken statistics counters.

Ports:
clk  input  1  system clock; all state updates on rising edge
rstn  input  1  synchronous active-low reset
id_valid  input  1  ID stage holds a valid instruction
id_is_branch_jump  input  1  ID instruction is BRANCH/JAL/JALR (from detector)
ex_resolve_valid  input  1  EX reports resolution of the pending transfer this cycle
ex_taken  input  1  transfer taken (always 1 for JAL/JALR)
ex_target  input  32  resolved target address
if_stall  output  1  hold PC and IF/ID register
id_bubble  output  1  replace ID output with NOP
if_flush  output  1  invalidate IF/ID contents
redirect_valid  output  1  load redirect_target into PC
redirect_target  output  32  redirect address, bit0 forced to 0
misalign_err  output  1  one-cycle pulse: taken target has bit1 set
timeout_err  output  1  one-cycle pulse: WAIT exceeded MAX_WAIT
branch_cnt  output  CNT_W  detected transfers, wraps
taken_cnt  output  CNT_W  taken transfers, wraps

Behaviour:
- States: IDLE, WAIT, REDIRECT. Reset (rstn=0 at a clk edge) forces IDLE, regardless of state, including mid-WAIT or mid-REDIRECT.
- Reset values: all registered outputs 0, redirect_target 0, counters 0, wait counter 0.
- Detection event = id_valid & id_is_branch_jump.

IDLE:
- if_stall = detection event. This is combinational, so the fall-through fetch is held in the same cycle.
- id_bubble = 0.
- On a detection event: go to WAIT, increment branch_cnt, clear the wait counter.
- ex_resolve_valid in IDLE is ignored.

WAIT:
- if_stall = 1 and id_bubble = 1, both registered and decoded from state.
- Wait counter increments each cycle.
- On ex_resolve_valid & ex_taken:
  - latch redirect_target = {ex_target[31:1],1'b0};
  - increment taken_cnt;
  - set misalign_err = ex_target[1] for the next cycle;
  - go to REDIRECT.
- On ex_resolve_valid & !ex_taken: go to IDLE. No redirect; fetch resumes at the held fall-through PC.
- Priority: resolution has priority over timeout in the same cycle.
- Timeout: if the wait counter reaches MAX_WAIT with no resolution, pulse timeout_err for one cycle and go to IDLE. No redirect, counters unchanged.
- Detection events in WAIT are ignored (ID is bubbled).

REDIRECT (exactly one cycle):
- redirect_valid = 1 and if_flush = 1.
- if_stall = 0 and id_bubble = 1.
- Always returns to IDLE next cycle.
- A detection event in this cycle is ignored, because the ID contents are stale and being flushed.

Other rules:
- redirect_valid is 0 outside REDIRECT.
- redirect_target holds its last value until the next taken resolution.
- Latency: detection at cycle N → WAIT at N+1. Taken resolution at cycle M → redirect_valid at M+1 → IDLE at M+2.
- Counters wrap modulo 2^CNT_W with no saturation.

Test Plan:
- Reset then idle: rstn=0 two cycles, then 1 → all outputs 0, counters 0; if_stall=0 with id_valid=1, id_is_branch_jump=0.
- Taken branch: detect at cycle 2, resolve taken at cycle 4 with ex_target=0x0000_1004 → if_stall=1 at cycles 2–4, redirect_valid=1 and if_flush=1 at cycle 5 with target 0x0000_1004, back in IDLE at cycle 6; branch_cnt=1, taken_cnt=1.
- Not-taken branch: detect, resolve taken=0 two cycles later → no redirect_valid, if_stall drops the cycle after resolution, taken_cnt=0, branch_cnt=1.
- JALR odd target: resolve taken with ex_target=0x0000_2003 → redirect_target=0x0000_2002 and misalign_err pulses once alongside redirect_valid.
- Timeout: detect with no resolution for MAX_WAIT=8 cycles → timeout_err pulse, IDLE, no redirect. Repeat with resolution arriving on the timeout cycle → redirect taken, no timeout_err.
- Reset mid-operation and ignored events: rstn=0 during WAIT → IDLE, if_stall=0 next cycle, counters cleared. Separately, a detection event during REDIRECT does not increment branch_cnt or enter WAIT.
